// File: rtl/nn_pkg.sv
// nn_pkg: shared image-loader sizes, byte type and FSM state encodings
package nn_pkg;
   localparam int IMG_LEN = 256;
   localparam int ADR_LEN = 9;
   typedef logic [7:0] UINT_8;
   typedef enum logic [1:0] {WAIT_SOF, FILL, HOLD} wr_state_t;
   typedef enum logic {IDLE, BUSY} rd_state_t;
endpackage

// File: rtl/img_bank.sv
// img_bank: ping-pong image banks, wsel picks the write bank, the other is read
module img_bank
   import nn_pkg::*;
#(
   parameter int    IMG_LEN  = nn_pkg::IMG_LEN,
   parameter int    ADR_LEN  = nn_pkg::ADR_LEN,
   parameter UINT_8 BIAS_VAL = 8'h00,
   parameter int    AW       = $clog2(IMG_LEN)
) (
   input  logic               clk,
   input  logic               wsel,
   input  logic               we,
   input  logic [AW-1:0]      wadr,
   input  UINT_8              wdata,
   input  logic [ADR_LEN-1:0] radr,
   output UINT_8              rdata
);
   UINT_8 bank0_q [IMG_LEN];
   UINT_8 bank1_q [IMG_LEN];
   logic [AW-1:0] ra;
   assign ra = radr[AW-1:0];
   // write only into the bank the NN is not reading; contents are never reset
   always_ff @(posedge clk) begin
      if (we && wsel) bank1_q[wadr] <= wdata;
      if (we && !wsel) bank0_q[wadr] <= wdata;
   end
   // out-of-image addresses return the bias byte
   always_comb begin
      rdata = (int'(radr) < IMG_LEN) ? (wsel ? bank0_q[ra] : bank1_q[ra]) : BIAS_VAL;
   end
endmodule

// File: rtl/img_loader.sv
// img_loader: streams pixel frames into a ping-pong buffer and hands full images to the NN
module img_loader #(
   parameter int         IMG_LEN  = nn_pkg::IMG_LEN,
   parameter int         ADR_LEN  = nn_pkg::ADR_LEN,
   parameter logic [7:0] BIAS_VAL = 8'h00
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_valid,
   input  logic               pix_sof,
   input  logic [7:0]         pix_data,
   output logic               pix_ready,
   input  logic [ADR_LEN-1:0] rd_adr,
   output logic [7:0]         rd_data,
   output logic               img_start,
   input  logic               nn_done,
   output logic               busy,
   output logic               err_short
);
   import nn_pkg::*;
   localparam int AW = $clog2(IMG_LEN);
   localparam logic [AW-1:0] LAST = AW'(IMG_LEN - 1);
   wr_state_t wst_q, wst_d;
   rd_state_t rds_q, rds_d;
   logic wsel_q, wsel_d, err_q, err_d, start_q, start_d;
   logic [AW-1:0] wcnt_q, wcnt_d, wadr;
   logic we, beat, frame_done, swap;
   // state registers; reset abandons any partial frame and frees the read bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wst_q   <= WAIT_SOF;
         rds_q   <= IDLE;
         wsel_q  <= 1'b0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         wst_q   <= wst_d;
         rds_q   <= rds_d;
         wsel_q  <= wsel_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
         start_q <= start_d;
      end
   end
   // write/read FSM next state; a swap hands the filled bank to the NN
   always_comb begin
      wst_d      = wst_q;
      rds_d      = rds_q;
      wsel_d     = wsel_q;
      wcnt_d     = wcnt_q;
      err_d      = err_q;
      start_d    = 1'b0;
      we         = 1'b0;
      wadr       = wcnt_q;
      frame_done = 1'b0;
      swap       = 1'b0;
      pix_ready  = wst_q != HOLD;
      beat       = pix_valid && pix_ready;
      case (wst_q)
         WAIT_SOF: if (beat && pix_sof) begin
            we     = 1'b1;
            wadr   = '0;
            wcnt_d = AW'(1);
            wst_d  = FILL;
         end
         FILL: if (beat) begin
            we = 1'b1;
            if (pix_sof) begin
               wadr   = '0;
               wcnt_d = AW'(1);
               err_d  = 1'b1;
            end else if (wcnt_q == LAST) frame_done = 1'b1;
            else wcnt_d = wcnt_q + 1'b1;
         end
         HOLD: swap = nn_done;
         default: wst_d = WAIT_SOF;
      endcase
      if (frame_done) begin
         wst_d = HOLD;
         swap  = rds_q == IDLE || nn_done;
      end
      if (swap) begin
         wsel_d  = ~wsel_q;
         wst_d   = WAIT_SOF;
         wcnt_d  = '0;
         rds_d   = BUSY;
         start_d = 1'b1;
      end else if (rds_q == BUSY && nn_done) rds_d = IDLE;
   end
   assign img_start = start_q;
   assign busy      = rds_q == BUSY;
   assign err_short = err_q;
   img_bank #(.IMG_LEN(IMG_LEN), .ADR_LEN(ADR_LEN), .BIAS_VAL(BIAS_VAL), .AW(AW)) u_bank (
      .clk   (clk),
      .wsel  (wsel_q),
      .we    (we),
      .wadr  (wadr),
      .wdata (pix_data),
      .radr  (rd_adr),
      .rdata (rd_data)
   );
endmodule

// File: tb/tb_img_loader.sv
// tb_img_loader: directed checks of frame loading, hold/swap handshake and reset
module tb_img_loader;
   localparam logic [7:0] BIAS = 8'hEE;
   logic clk = 1'b0, reset = 1'b1, pix_valid = 1'b0, pix_sof = 1'b0, nn_done = 1'b0;
   logic [7:0] pix_data = '0;
   logic [8:0] rd_adr = '0;
   logic pix_ready, img_start, busy, err_short;
   logic [7:0] rd_data;
   int checks = 0, failures = 0, starts = 0, s0;
   img_loader #(.BIAS_VAL(BIAS)) dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .pix_data(pix_data), .pix_ready(pix_ready), .rd_adr(rd_adr), .rd_data(rd_data),
      .img_start(img_start), .nn_done(nn_done), .busy(busy), .err_short(err_short)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (img_start) starts++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   // n beats; data = (i & mask) ^ x; optional sof on beat 0 and nn_done on the last beat
   task automatic send(input int n, input logic [7:0] mask, input logic [7:0] x,
                       input bit sof, input bit done_last);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pix_valid = 1'b1;
         pix_sof   = sof && i == 0;
         pix_data  = (8'(i) & mask) ^ x;
         nn_done   = done_last && i == n - 1;
      end
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      nn_done   = 1'b0;
   endtask
   task automatic rd(input string tag, input int a, input logic [7:0] exp);
      rd_adr = 9'(a);
      #1 chk(tag, {24'd0, rd_data}, {24'd0, exp});
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, pix_ready}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_err", {31'd0, err_short}, 0);
      chk("rst_start", {31'd0, img_start}, 0);
      reset = 1'b0;
      send(30, 8'hFF, 8'h00, 1'b0, 1'b0);
      chk("nosof_ready", {31'd0, pix_ready}, 1);
      chk("nosof_starts", starts, 0);
      chk("nosof_busy", {31'd0, busy}, 0);
      send(256, 8'hFF, 8'h00, 1'b1, 1'b0);
      chk("f1_start", {31'd0, img_start}, 1);
      chk("f1_busy", {31'd0, busy}, 1);
      rd("f1_rd37", 37, 8'd37);
      rd("f1_rd255", 255, 8'd255);
      rd("f1_bias", 256, BIAS);
      @(negedge clk);
      chk("f1_pulse_end", {31'd0, img_start}, 0);
      chk("f1_starts", starts, 1);
      send(256, 8'h00, 8'hA5, 1'b1, 1'b0);
      chk("f2_hold_ready", {31'd0, pix_ready}, 0);
      chk("f2_no_start", {31'd0, img_start}, 0);
      rd("f2_old_rd5", 5, 8'd5);
      nn_done = 1'b1;
      @(negedge clk);
      nn_done = 1'b0;
      chk("f2_start", {31'd0, img_start}, 1);
      chk("f2_ready", {31'd0, pix_ready}, 1);
      rd("f2_rd5", 5, 8'hA5);
      chk("f2_busy", {31'd0, busy}, 1);
      send(256, 8'hFF, 8'hFF, 1'b1, 1'b1);
      chk("f3_start", {31'd0, img_start}, 1);
      chk("f3_ready", {31'd0, pix_ready}, 1);
      chk("f3_busy", {31'd0, busy}, 1);
      rd("f3_rd5", 5, 8'hFA);
      @(negedge clk);
      nn_done = 1'b1;
      @(negedge clk);
      nn_done = 1'b0;
      chk("done_idle", {31'd0, busy}, 0);
      s0 = starts;
      send(100, 8'h00, 8'h11, 1'b1, 1'b0);
      chk("short_err0", {31'd0, err_short}, 0);
      send(256, 8'hFF, 8'h5A, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("short_err", {31'd0, err_short}, 1);
      chk("short_starts", starts - s0, 1);
      rd("short_rd0", 0, 8'h5A);
      rd("short_rd100", 100, 8'h3E);
      send(128, 8'hFF, 8'h00, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid_ready", {31'd0, pix_ready}, 1);
      chk("mid_busy", {31'd0, busy}, 0);
      chk("mid_err", {31'd0, err_short}, 0);
      chk("mid_start", {31'd0, img_start}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_busy", {31'd0, busy}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
